// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and width helpers for the rr_mux_arb mux/arbiter
// Purpose: arbitration mode encodings and select-index width derivation.
// Contents: MODE_FIXED, MODE_RR, clog2(), sel_width() = max(1, clog2(n)).
package rr_mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A single channel still needs a 1-bit index port.
   function automatic int sel_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - combinational fixed-priority / round-robin grant with packet lock
// Purpose: pick one requester from req and return it one-hot plus encoded.
// Ports:
//   req      in   NUM_CH  request vector
//   ptr      in   SELW    last round-robin winner; search starts at ptr+1
//   locked   in   1       restrict grant to lock_ch
//   lock_ch  in   SELW    channel the arbiter is locked to
//   grant    out  NUM_CH  one-hot grant, zero when nothing eligible
//   idx      out  SELW    encoded grant index (0 when no grant)
module rr_mux_arbiter
   import rr_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int MODE   = MODE_RR,
   parameter int SELW   = sel_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SELW-1:0]   ptr,
   input  logic              locked,
   input  logic [SELW-1:0]   lock_ch,
   output logic [NUM_CH-1:0] grant,
   output logic [SELW-1:0]   idx
);

   always_comb begin
      grant = '0;
      idx   = '0;
      if (locked) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if ((int'(lock_ch) == k) && req[k]) begin
               grant[k] = 1'b1;
               idx      = SELW'(k);
            end
         end
      end else if (MODE == MODE_FIXED) begin
         // Scan downwards so the lowest requesting index is the last write.
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
               grant    = '0;
               grant[k] = 1'b1;
               idx      = SELW'(k);
            end
         end
      end else begin
         // Offset i=1 (channel ptr+1) is highest priority, so scan offsets downwards.
         for (int i = NUM_CH; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NUM_CH]) begin
               grant = '0;
               grant[(int'(ptr) + i) % NUM_CH] = 1'b1;
               idx   = SELW'((int'(ptr) + i) % NUM_CH);
            end
         end
      end
   end

endmodule

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N-to-1 registered mux with valid/ready handshake and built-in arbitration
// Purpose: arbitrate NUM_CH requesters and register the winner into a one-entry output stage.
// Optional feature: define RR_MUX_LOCK_EN to add last_i and packet locking.
// Ports:
//   clk_i    in   1             clock
//   rst_i    in   1             synchronous reset, active-high
//   valid_i  in   NUM_CH        per-channel request
//   data_i   in   NUM_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   last_i   in   NUM_CH        end-of-packet per channel (RR_MUX_LOCK_EN only)
//   ready_o  out  NUM_CH        per-channel accept, one-hot or zero
//   valid_o  out  1             output entry valid
//   data_o   out  WIDTH         output data
//   sel_o    out  SELW          channel index held in output stage
//   ready_i  in   1             sink accept
module rr_mux_arb
   import rr_mux_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_CH = 4,
   parameter  int MODE   = MODE_RR,
   localparam int SELW   = sel_width(NUM_CH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_CH-1:0]       valid_i,
   input  logic [NUM_CH*WIDTH-1:0] data_i,
`ifdef RR_MUX_LOCK_EN
   input  logic [NUM_CH-1:0]       last_i,
`endif
   output logic [NUM_CH-1:0]       ready_o,
   output logic                    valid_o,
   output logic [WIDTH-1:0]        data_o,
   output logic [SELW-1:0]         sel_o,
   input  logic                    ready_i
);

   logic              load;
   logic              xfer;
   logic              ptr_upd;
   logic [NUM_CH-1:0] grant;
   logic [SELW-1:0]   idx;
   logic [SELW-1:0]   ptr_q;
   logic              locked_q;
   logic [SELW-1:0]   lock_ch_q;
   logic [WIDTH-1:0]  data_sel;

   rr_mux_arbiter #(
      .NUM_CH (NUM_CH),
      .MODE   (MODE),
      .SELW   (SELW)
   ) u_arbiter (
      .req     (valid_i),
      .ptr     (ptr_q),
      .locked  (locked_q),
      .lock_ch (lock_ch_q),
      .grant   (grant),
      .idx     (idx)
   );

   // Output stage can take a beat when empty or draining this cycle.
   assign load = !valid_o || ready_i;

   always_comb begin
      ready_o = '0;
      if (!rst_i && load) ready_o = grant;
   end

   assign xfer = |(valid_i & ready_o);

   always_comb begin
      data_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(idx) == k) data_sel = data_i[k*WIDTH +: WIDTH];
      end
   end

`ifdef RR_MUX_LOCK_EN
   // ready_o is one-hot, so this picks last_i of the transferring channel.
   assign ptr_upd = |(ready_o & last_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         locked_q  <= 1'b0;
         lock_ch_q <= '0;
      end else if (xfer) begin
         locked_q  <= !ptr_upd;
         lock_ch_q <= idx;
      end
   end
`else
   assign ptr_upd   = 1'b1;
   assign locked_q  = 1'b0;
   assign lock_ch_q = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         data_o  <= '0;
         sel_o   <= '0;
         ptr_q   <= SELW'(NUM_CH - 1);
      end else if (load) begin
         valid_o <= xfer;
         if (xfer) begin
            data_o <= data_sel;
            sel_o  <= idx;
            if ((MODE == MODE_RR) && ptr_upd) ptr_q <= idx;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - self-checking bench for rr_mux_arb against a behavioural model
module tb_rr_mux_arb;

   localparam int W  = 32;
   localparam int NC = 4;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [NC-1:0]   valid_i;
   logic [NC*W-1:0] data_i;
   logic            ready_i;
`ifdef RR_MUX_LOCK_EN
   logic [NC-1:0]   last_i;
`endif

   logic [NC-1:0]   ready_rr, ready_fx;
   logic            valid_rr, valid_fx;
   logic [W-1:0]    data_rr, data_fx;
   logic [1:0]      sel_rr, sel_fx;

   always #5 clk = ~clk;

   rr_mux_arb #(.WIDTH(W), .NUM_CH(NC), .MODE(1)) dut_rr (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
`ifdef RR_MUX_LOCK_EN
      .last_i(last_i),
`endif
      .ready_o(ready_rr), .valid_o(valid_rr), .data_o(data_rr), .sel_o(sel_rr), .ready_i(ready_i)
   );

   rr_mux_arb #(.WIDTH(W), .NUM_CH(NC), .MODE(0)) dut_fx (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
`ifdef RR_MUX_LOCK_EN
      .last_i(last_i),
`endif
      .ready_o(ready_fx), .valid_o(valid_fx), .data_o(data_fx), .sel_o(sel_fx), .ready_i(ready_i)
   );

   // Model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
   bit           m_valid [2];
   logic [W-1:0] m_data  [2];
   int           m_sel   [2];
   int           m_ptr   [2];
   bit           m_lock  [2];
   int           m_lch   [2];

   int n_cmp = 0;
   int n_fail = 0;
   bit cmp_en = 0;
   int acc_rr = -1;
   logic [NC-1:0] pend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int exp_grant(input int d);
      if (rst_i) return -1;
      if (m_valid[d] && !ready_i) return -1;
      if (m_lock[d]) return valid_i[m_lch[d]] ? m_lch[d] : -1;
      for (int i = 1; i <= NC; i++) begin
         int c = (d == 0) ? (m_ptr[d] + i) % NC : i - 1;
         if (valid_i[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_update(input int d, input int g);
      if (rst_i) begin
         m_valid[d] = 0; m_data[d] = '0; m_sel[d] = 0; m_ptr[d] = NC - 1;
         m_lock[d] = 0; m_lch[d] = 0;
      end else if (!m_valid[d] || ready_i) begin
         if (g >= 0) begin
            m_valid[d] = 1;
            m_data[d]  = data_i[g*W +: W];
            m_sel[d]   = g;
`ifdef RR_MUX_LOCK_EN
            m_lock[d] = !last_i[g];
            m_lch[d]  = g;
            if (last_i[g]) m_ptr[d] = g;
`else
            m_ptr[d] = g;
`endif
         end else begin
            m_valid[d] = 0;
         end
      end
   endtask

   task automatic cmp_model();
      for (int d = 0; d < 2; d++) begin
         int g = exp_grant(d);
         logic [NC-1:0] er = (g < 0) ? '0 : NC'(1 << g);
         if (d == 0) begin
            chk("rr_ready", 32'(ready_rr), 32'(er));
            chk("rr_valid", 32'(valid_rr), 32'(m_valid[0]));
            chk("rr_data", data_rr, m_data[0]);
            chk("rr_sel", 32'(sel_rr), m_sel[0]);
         end else begin
            chk("fx_ready", 32'(ready_fx), 32'(er));
            chk("fx_valid", 32'(valid_fx), 32'(m_valid[1]));
            chk("fx_data", data_fx, m_data[1]);
            chk("fx_sel", 32'(sel_fx), m_sel[1]);
         end
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      int g0, g1;
      #1;
      if (cmp_en) cmp_model();
      g0 = exp_grant(0);
      g1 = exp_grant(1);
      @(posedge clk);
      model_update(0, g0);
      model_update(1, g1);
      acc_rr = g0;
      @(negedge clk);
   endtask

   task automatic set_abcd();
      for (int k = 0; k < NC; k++) data_i[k*W +: W] = 32'hA0 + k;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 0; m_data[d] = '0; m_sel[d] = 0; m_ptr[d] = NC - 1;
         m_lock[d] = 0; m_lch[d] = 0;
      end
      rst_i = 1; valid_i = '1; ready_i = 0; set_abcd();
`ifdef RR_MUX_LOCK_EN
      last_i = '1;
`endif
      @(negedge clk);
      #1;
      chk("reset_ready_rr", 32'(ready_rr), 32'h0);
      chk("reset_ready_fx", 32'(ready_fx), 32'h0);
      tick();
      cmp_en = 1;
      chk("reset_valid", 32'(valid_rr), 32'h0);
      chk("reset_data", data_rr, 32'h0);
      chk("reset_sel", 32'(sel_rr), 32'h0);

      // Round-robin rotation with everybody requesting.
      rst_i = 0; ready_i = 1; valid_i = '1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_seq_data", data_rr, 32'hA0 + (i % 4));
         chk("fx_seq_data", data_fx, 32'hA0);
      end

      // Fixed priority starves ch3.
      valid_i = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1 chk("fx_1010_ready", 32'(ready_fx), 32'h2);
         tick();
         chk("fx_1010_sel", 32'(sel_fx), 32'h1);
      end

      // Backpressure holds the output stage.
      rst_i = 1; tick();
      rst_i = 0; valid_i = '1; ready_i = 1; tick();
      chk("bp_first", data_rr, 32'hA0);
      ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", 32'(ready_rr), 32'h0);
         tick();
         chk("bp_hold_data", data_rr, 32'hA0);
         chk("bp_hold_valid", 32'(valid_rr), 32'h1);
      end
      ready_i = 1;
      #1 chk("bp_release_ready", 32'(ready_rr), 32'h2);
      tick();
      chk("bp_next", data_rr, 32'hA1);

      // Reset while the output stage is full and stalled.
      ready_i = 0; rst_i = 1;
      #1 chk("rst_mid_ready", 32'(ready_rr), 32'h0);
      tick();
      chk("rst_mid_valid", 32'(valid_rr), 32'h0);
      rst_i = 0; ready_i = 1; tick();
      chk("rst_mid_ch0", data_rr, 32'hA0);

`ifdef RR_MUX_LOCK_EN
      rst_i = 1; tick();
      rst_i = 0; valid_i = 4'b0100; last_i = 4'b0000; tick();
      chk("lock_b0", 32'(sel_rr), 32'h2);
      valid_i = 4'b0111; tick();
      chk("lock_b1", 32'(sel_rr), 32'h2);
      last_i = 4'b0100; tick();
      chk("lock_b2", 32'(sel_rr), 32'h2);
      valid_i = 4'b0011; last_i = 4'b1111; tick();
      chk("lock_after", 32'(sel_rr), 32'h0);
`endif

      // Randomised traffic; sources hold valid/data until the RR DUT accepts.
      pend = '0;
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < NC; k++) begin
            if (!pend[k] && $urandom_range(0, 2) != 0) begin
               pend[k] = 1'b1;
               data_i[k*W +: W] = $urandom;
`ifdef RR_MUX_LOCK_EN
               last_i[k] = ($urandom_range(0, 2) == 0);
`endif
            end
         end
         valid_i = pend;
         ready_i = ($urandom_range(0, 3) != 0);
         rst_i   = ($urandom_range(0, 79) == 0);
         tick();
         if (acc_rr >= 0) pend[acc_rr] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
